bambu_mem_channel_arbiter: RTL

//  Shares one single-port off-chip memory between the two master lanes of a Bambu-generated

---
 rtl/bambu_mem_channel_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bambu_mem_channel_arbiter.sv
// bambu_mem_channel_arbiter
// Shares one single-port, fixed-latency memory between the two master lanes of a
// Bambu dual-channel bus. Requests are serialised with round-robin priority on
// conflicts. Each access runs IDLE -> CMD -> WAIT -> REL. The REL cycle absorbs the
// master's request, which is still high in the cycle after DataRdy.
module bambu_mem_channel_arbiter #(
    parameter int ADDR_W          = 7,
    parameter int DATA_W          = 8,
    parameter int SIZE_W          = 4,
    parameter int MEM_DELAY_READ  = 2,
    parameter int MEM_DELAY_WRITE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          Mout_oe_ram,
    input  logic [1:0]          Mout_we_ram,
    input  logic [2*ADDR_W-1:0] Mout_addr_ram,
    input  logic [2*DATA_W-1:0] Mout_Wdata_ram,
    input  logic [2*SIZE_W-1:0] Mout_data_ram_size,
    output logic [2*DATA_W-1:0] M_Rdata_ram,
    output logic [1:0]          M_DataRdy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [SIZE_W-1:0]   mem_size,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                protocol_err
);

    localparam int MAX_D = (MEM_DELAY_READ > MEM_DELAY_WRITE) ? MEM_DELAY_READ : MEM_DELAY_WRITE;
    localparam int CNT_W = $clog2(MAX_D + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t              state_r, state_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic                grant_r, grant_n;
    logic                last_grant_r, last_grant_n;
    logic                op_we_r, op_we_n;
    logic [ADDR_W-1:0]   addr_r, addr_n;
    logic [DATA_W-1:0]   wdata_r, wdata_n;
    logic [SIZE_W-1:0]   size_r, size_n;
    logic                mem_en_r, mem_en_n;
    logic                mem_we_r, mem_we_n;
    logic [1:0]          rdy_r, rdy_n;
    logic                perr_r, perr_n;

    logic [1:0]          valid_s;
    logic [1:0]          bad_s;
    logic                pick_s;
    logic [CNT_W-1:0]    delay_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [1:0]          grant_onehot_s;

    assign valid_s        = Mout_oe_ram ^ Mout_we_ram;
    assign bad_s          = Mout_oe_ram & Mout_we_ram;
    assign delay_s        = op_we_r ? CNT_W'(MEM_DELAY_WRITE) : CNT_W'(MEM_DELAY_READ);
    assign cnt_inc_s      = cnt_r + CNT_ONE;
    assign grant_onehot_s = grant_r ? 2'b10 : 2'b01;

    assign mem_en       = mem_en_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign mem_size     = size_r;
    assign M_DataRdy    = rdy_r;
    assign protocol_err = perr_r;

    // Lane selection: on a conflict the lane that lost the previous conflict wins.
    always_comb begin
        pick_s = 1'b0;
        if (valid_s == 2'b11) begin
            pick_s = ~last_grant_r;
        end else if (valid_s[1]) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        grant_n      = grant_r;
        last_grant_n = last_grant_r;
        op_we_n      = op_we_r;
        addr_n       = addr_r;
        wdata_n      = wdata_r;
        size_n       = size_r;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        rdy_n        = 2'b00;
        perr_n       = perr_r;
        case (state_r)
            ST_IDLE: begin
                if (bad_s != 2'b00) begin
                    perr_n = 1'b1;
                end else begin
                    perr_n = perr_r;
                end
                if (valid_s != 2'b00) begin
                    grant_n  = pick_s;
                    op_we_n  = Mout_we_ram[pick_s];
                    addr_n   = pick_s ? Mout_addr_ram[2*ADDR_W-1:ADDR_W] : Mout_addr_ram[ADDR_W-1:0];
                    wdata_n  = pick_s ? Mout_Wdata_ram[2*DATA_W-1:DATA_W] : Mout_Wdata_ram[DATA_W-1:0];
                    size_n   = pick_s ? Mout_data_ram_size[2*SIZE_W-1:SIZE_W] : Mout_data_ram_size[SIZE_W-1:0];
                    mem_en_n = 1'b1;
                    mem_we_n = Mout_we_ram[pick_s];
                    state_n  = ST_CMD;
                    // Priority only rotates when a real conflict was resolved.
                    if (valid_s == 2'b11) begin
                        last_grant_n = pick_s;
                    end else begin
                        last_grant_n = last_grant_r;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD: begin
                state_n = ST_WAIT;
                cnt_n   = CNT_ONE;
                if (delay_s == CNT_ONE) begin
                    rdy_n = grant_onehot_s;
                end else begin
                    rdy_n = 2'b00;
                end
            end
            ST_WAIT: begin
                if (cnt_r == delay_s) begin
                    state_n = ST_REL;
                end else begin
                    state_n = ST_WAIT;
                    cnt_n   = cnt_inc_s;
                    if (cnt_inc_s == delay_s) begin
                        rdy_n = grant_onehot_s;
                    end else begin
                        rdy_n = 2'b00;
                    end
                end
            end
            ST_REL: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            op_we_r      <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            size_r       <= {SIZE_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            rdy_r        <= 2'b00;
            perr_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
            op_we_r      <= op_we_n;
            addr_r       <= addr_n;
            wdata_r      <= wdata_n;
            size_r       <= size_n;
            mem_en_r     <= mem_en_n;
            mem_we_r     <= mem_we_n;
            rdy_r        <= rdy_n;
            perr_r       <= perr_n;
        end
    end

    // Read data passes straight from memory in the completion cycle; other lanes read 0.
    always_comb begin
        M_Rdata_ram = {(2*DATA_W){1'b0}};
        if (rdy_r[0] && !op_we_r) begin
            M_Rdata_ram[DATA_W-1:0] = mem_rdata;
        end else begin
            M_Rdata_ram[DATA_W-1:0] = {DATA_W{1'b0}};
        end
        if (rdy_r[1] && !op_we_r) begin
            M_Rdata_ram[2*DATA_W-1:DATA_W] = mem_rdata;
        end else begin
            M_Rdata_ram[2*DATA_W-1:DATA_W] = {DATA_W{1'b0}};
        end
    end

endmodule
